flash_rd_arbiter: RTL and testbench

Shares one quad-I/O flash line reader between two independent line requesters: port 0 is the instruction-fetch cache controller and port 1 is the data/DMA flash port. Each requester issues single-cycle read pulses. The block latches each request, arbitrates round-robin, and sequences exactly one reader transaction at a time. It returns a registered done pulse and a held line buffer to the requester that owns each transaction. It sits between the cache controllers and the flash reader; its reader-side port matches the reader's addr/rd/done/line interface exactly.

---
 rtl/flash_arb_pkg.sv | 22 ++
 rtl/flash_arb_port.sv | 57 +++++
 rtl/flash_rd_arbiter.sv | 146 ++++++++++++++
 tb/tb_flash_rd_arbiter.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flash_arb_pkg.sv
// Shared types and constants for the two-port flash line-read arbiter.
// Optional FLASH_ARB_FIXED_PRIO_EN selects fixed port-0 priority.
package flash_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        BUSY  = 2'b10
    } state_t;

    localparam int LINE_SIZE_DEF = 128;
    localparam int LINE_BYTES    = LINE_SIZE_DEF / 8;
    localparam int OFFSET_W      = $clog2(LINE_BYTES);

    localparam int P0 = 0;
    localparam int P1 = 1;

    function automatic int offset_w(input int line_size);
        return $clog2(line_size / 8);
    endfunction

endpackage

// File: rtl/flash_arb_port.sv
// Per-requester state: pending latch, aligned address, line buffer,
// registered done pulse and sticky drop flag.
module flash_arb_port
    import flash_arb_pkg::*;
#(
    parameter int LINE_SIZE = LINE_SIZE_DEF,
    parameter int ADDR_W    = 24
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rd,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic                 in_service,
    input  logic                 take,
    input  logic                 fin,
    input  logic [LINE_SIZE-1:0] fill,
    output logic                 pend,
    output logic [ADDR_W-1:0]    addr,
    output logic                 done,
    output logic [LINE_SIZE-1:0] line,
    output logic                 err
);

    localparam int OFF_W = offset_w(LINE_SIZE);

    logic drop;
    logic accept;

    assign drop   = rd && (pend || in_service);
    assign accept = rd && !drop;

    // take only fires while pend is set, so it never races with accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= 1'b0;
            addr <= '0;
            done <= 1'b0;
            line <= '0;
            err  <= 1'b0;
        end else begin
            done <= fin;
            if (fin) begin
                line <= fill;
            end
            if (drop) begin
                err <= 1'b1;
            end
            if (accept) begin
                pend <= 1'b1;
                addr <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            end else if (take) begin
                pend <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/flash_rd_arbiter.sv
// Two-port round-robin arbiter in front of one flash line reader.
// Define FLASH_ARB_FIXED_PRIO_EN to give port 0 fixed priority instead.
module flash_rd_arbiter
    import flash_arb_pkg::*;
#(
    parameter int LINE_SIZE = LINE_SIZE_DEF,
    parameter int ADDR_W    = 24
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic [ADDR_W-1:0]    r0_addr,
    input  logic                 r0_rd,
    input  logic [ADDR_W-1:0]    r1_addr,
    input  logic                 r1_rd,
    output logic                 r0_done,
    output logic                 r1_done,
    output logic [LINE_SIZE-1:0] r0_line,
    output logic [LINE_SIZE-1:0] r1_line,
    output logic [ADDR_W-1:0]    fr_addr,
    output logic                 fr_rd,
    input  logic                 fr_done,
    input  logic [LINE_SIZE-1:0] fr_line,
    output logic                 busy,
    output logic [1:0]           err
);

    state_t state;
    logic   gnt;
    logic   sel;
    logic   start;

    logic [1:0]        pend;
    logic [1:0]        take;
    logic [1:0]        fin;
    logic [1:0]        in_service;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;

`ifdef FLASH_ARB_FIXED_PRIO_EN
    always_comb begin
        sel = pend[P0] ? 1'(P0) : 1'(P1);
    end
`else
    logic last_gnt;

    // on a tie the port that did not win last time goes next
    always_comb begin
        if (&pend) begin
            sel = ~last_gnt;
        end else begin
            sel = pend[P1];
        end
    end
`endif

    assign start = (state == IDLE) && (|pend);

    always_comb begin
        take       = '0;
        fin        = '0;
        in_service = '0;
        take[sel]  = start;
        fin[gnt]   = (state == BUSY) && fr_done;
        in_service[gnt] = (state != IDLE);
    end

    assign busy = (state != IDLE) || (|pend);

    flash_arb_port #(
        .LINE_SIZE (LINE_SIZE),
        .ADDR_W    (ADDR_W)
    ) u_port0 (
        .clk        (HCLK),
        .rst_n      (HRESETn),
        .rd         (r0_rd),
        .req_addr   (r0_addr),
        .in_service (in_service[P0]),
        .take       (take[P0]),
        .fin        (fin[P0]),
        .fill       (fr_line),
        .pend       (pend[P0]),
        .addr       (addr0),
        .done       (r0_done),
        .line       (r0_line),
        .err        (err[P0])
    );

    flash_arb_port #(
        .LINE_SIZE (LINE_SIZE),
        .ADDR_W    (ADDR_W)
    ) u_port1 (
        .clk        (HCLK),
        .rst_n      (HRESETn),
        .rd         (r1_rd),
        .req_addr   (r1_addr),
        .in_service (in_service[P1]),
        .take       (take[P1]),
        .fin        (fin[P1]),
        .fill       (fr_line),
        .pend       (pend[P1]),
        .addr       (addr1),
        .done       (r1_done),
        .line       (r1_line),
        .err        (err[P1])
    );

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state   <= IDLE;
            gnt     <= 1'b0;
            fr_addr <= '0;
            fr_rd   <= 1'b0;
`ifndef FLASH_ARB_FIXED_PRIO_EN
            last_gnt <= 1'b1;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        gnt     <= sel;
                        fr_addr <= sel ? addr1 : addr0;
                        fr_rd   <= 1'b1;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    fr_rd <= 1'b0;
`ifndef FLASH_ARB_FIXED_PRIO_EN
                    last_gnt <= gnt;
`endif
                    state <= BUSY;
                end
                BUSY: begin
                    if (fr_done) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    fr_rd <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flash_rd_arbiter.sv
// Directed bench for flash_rd_arbiter with a hand-driven reader model.
// Expectations follow FLASH_ARB_FIXED_PRIO_EN when it is defined.
module tb_flash_rd_arbiter;

    logic         HCLK = 1'b0;
    logic         HRESETn = 1'b0;
    logic [23:0]  r0_addr = '0;
    logic [23:0]  r1_addr = '0;
    logic         r0_rd = 1'b0;
    logic         r1_rd = 1'b0;
    logic         r0_done;
    logic         r1_done;
    logic [127:0] r0_line;
    logic [127:0] r1_line;
    logic [23:0]  fr_addr;
    logic         fr_rd;
    logic         fr_done = 1'b0;
    logic [127:0] fr_line = '0;
    logic         busy;
    logic [1:0]   err;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] LA =
        {8'hA5, 112'h0123456789ABCDEF0123456789AB, 8'h5A};
    localparam logic [127:0] LB = {4{32'hDEADBEEF}};
    localparam logic [127:0] LC = {4{32'h11112222}};
    localparam logic [127:0] LD = {2{64'h0F0FF0F03C3CC3C3}};
    localparam logic [127:0] LE = {4{32'hCAFEF00D}};

    flash_rd_arbiter #(
        .LINE_SIZE (128),
        .ADDR_W    (24)
    ) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .r0_addr (r0_addr),
        .r0_rd   (r0_rd),
        .r1_addr (r1_addr),
        .r1_rd   (r1_rd),
        .r0_done (r0_done),
        .r1_done (r1_done),
        .r0_line (r0_line),
        .r1_line (r1_line),
        .fr_addr (fr_addr),
        .fr_rd   (fr_rd),
        .fr_done (fr_done),
        .fr_line (fr_line),
        .busy    (busy),
        .err     (err)
    );

    always #5 HCLK = ~HCLK;

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic wait_fr_rd(output int n);
        n = 0;
        while (fr_rd !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic do_reset();
        HRESETn = 1'b0;
        r0_rd = 1'b0;
        r1_rd = 1'b0;
        fr_done = 1'b0;
        tick();
        tick();
        HRESETn = 1'b1;
        tick();
    endtask

    // entered in the ISSUE cycle; leaves in the cycle the done pulse shows
    task automatic serve(input logic [23:0] a, input logic [127:0] l);
        tick();
        checks++;
        if (fr_rd !== 1'b0) begin
            errors++;
            $display("FAIL serve_fr_rd_pulse: got %b want 0", fr_rd);
        end
        checks++;
        if (fr_addr !== a) begin
            errors++;
            $display("FAIL serve_addr_hold: got %h want %h", fr_addr, a);
        end
        tick();
        fr_done = 1'b1;
        fr_line = l;
        tick();
        fr_done = 1'b0;
        fr_line = '0;
    endtask

    task automatic test_reset();
        HRESETn = 1'b0;
        tick();
        checks++;
        if ({fr_rd, busy, r0_done, r1_done} !== 4'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 0000",
                     {fr_rd, busy, r0_done, r1_done});
        end
        checks++;
        if (err !== 2'b00 || fr_addr !== 24'h0) begin
            errors++;
            $display("FAIL reset_err_addr: got %b %h want 00 000000",
                     err, fr_addr);
        end
        checks++;
        if (r0_line !== '0 || r1_line !== '0) begin
            errors++;
            $display("FAIL reset_lines: got %h %h want 0", r0_line, r1_line);
        end
        tick();
        HRESETn = 1'b1;
        tick();
    endtask

    task automatic test_single();
        int n;
        r0_rd = 1'b1;
        r0_addr = 24'h001237;
        tick();
        r0_rd = 1'b0;
        wait_fr_rd(n);
        checks++;
        if (n != 1) begin
            errors++;
            $display("FAIL single_latency: got %0d want 1", n);
        end
        checks++;
        if (fr_addr !== 24'h001230 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_addr: got %h busy %b want 001230 1",
                     fr_addr, busy);
        end
        serve(24'h001230, LA);
        checks++;
        if (r0_done !== 1'b1 || r1_done !== 1'b0) begin
            errors++;
            $display("FAIL single_done: got %b%b want 10", r0_done, r1_done);
        end
        checks++;
        if (r0_line !== LA || r1_line !== '0) begin
            errors++;
            $display("FAIL single_line: got %h %h want %h 0",
                     r0_line, r1_line, LA);
        end
        tick();
        checks++;
        if (r0_done !== 1'b0 || r0_line !== LA || err !== 2'b00) begin
            errors++;
            $display("FAIL single_hold: got %b %h %b want 0 %h 00",
                     r0_done, r0_line, err, LA);
        end
    endtask

    task automatic test_spurious();
        fr_done = 1'b1;
        fr_line = LB;
        tick();
        fr_done = 1'b0;
        fr_line = '0;
        checks++;
        if (r0_done !== 1'b0 || r1_done !== 1'b0) begin
            errors++;
            $display("FAIL spurious_done: got %b%b want 00", r0_done, r1_done);
        end
        checks++;
        if (r0_line !== LA || r1_line !== '0) begin
            errors++;
            $display("FAIL spurious_lines: got %h %h want %h 0",
                     r0_line, r1_line, LA);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || fr_rd !== 1'b0) begin
            errors++;
            $display("FAIL spurious_idle: got busy %b fr_rd %b want 0 0",
                     busy, fr_rd);
        end
    endtask

    task automatic run_pair(input bit first1,
                            input logic [23:0] a0, input logic [23:0] a1,
                            input logic [127:0] l0, input logic [127:0] l1);
        int n;
        bit p;
        logic [23:0] ea;
        r0_rd = 1'b1;
        r1_rd = 1'b1;
        r0_addr = a0;
        r1_addr = a1;
        tick();
        r0_rd = 1'b0;
        r1_rd = 1'b0;
        for (int k = 0; k < 2; k++) begin
            p = (k == 0) ? first1 : !first1;
            ea = p ? a1 : a0;
            wait_fr_rd(n);
            checks++;
            if (n != 1) begin
                errors++;
                $display("FAIL tie_latency[%0d]: got %0d want 1", k, n);
            end
            checks++;
            if (fr_addr !== ea) begin
                errors++;
                $display("FAIL tie_order[%0d]: got %h want %h", k, fr_addr, ea);
            end
            serve(ea, p ? l1 : l0);
            checks++;
            if (r0_done !== !p || r1_done !== p) begin
                errors++;
                $display("FAIL tie_done[%0d]: got %b%b want %b%b",
                         k, r0_done, r1_done, !p, p);
            end
        end
        checks++;
        if (r0_line !== l0 || r1_line !== l1 || err !== 2'b00) begin
            errors++;
            $display("FAIL tie_lines: got %h %h %b want %h %h 00",
                     r0_line, r1_line, err, l0, l1);
        end
        tick();
    endtask

    task automatic test_tie();
        int n;
        bit second_first1;
        do_reset();
        run_pair(1'b0, 24'h000100, 24'h000200, LB, LC);
        r0_rd = 1'b1;
        r0_addr = 24'h000500;
        tick();
        r0_rd = 1'b0;
        wait_fr_rd(n);
        serve(24'h000500, LA);
        checks++;
        if (r0_done !== 1'b1 || r0_line !== LA) begin
            errors++;
            $display("FAIL tie_mid_single: got %b %h want 1 %h",
                     r0_done, r0_line, LA);
        end
        tick();
`ifdef FLASH_ARB_FIXED_PRIO_EN
        second_first1 = 1'b0;
`else
        second_first1 = 1'b1;
`endif
        run_pair(second_first1, 24'h000300, 24'h000400, LD, LE);
    endtask

    task automatic test_dup();
        int n;
        int cnt;
        do_reset();
        r1_rd = 1'b1;
        r1_addr = 24'h000345;
        tick();
        r1_rd = 1'b0;
        wait_fr_rd(n);
        checks++;
        if (n != 1 || fr_addr !== 24'h000340) begin
            errors++;
            $display("FAIL dup_issue: got %0d %h want 1 000340", n, fr_addr);
        end
        tick();
        r1_rd = 1'b1;
        r1_addr = 24'h000999;
        tick();
        r1_rd = 1'b0;
        checks++;
        if (err !== 2'b10 || busy !== 1'b1) begin
            errors++;
            $display("FAIL dup_err: got %b busy %b want 10 1", err, busy);
        end
        fr_done = 1'b1;
        fr_line = LC;
        tick();
        fr_done = 1'b0;
        fr_line = '0;
        checks++;
        if (r1_done !== 1'b1 || r1_line !== LC) begin
            errors++;
            $display("FAIL dup_done: got %b %h want 1 %h", r1_done, r1_line, LC);
        end
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (fr_rd === 1'b1) cnt++;
        end
        checks++;
        if (cnt != 0 || busy !== 1'b0 || err !== 2'b10) begin
            errors++;
            $display("FAIL dup_no_reissue: got %0d busy %b err %b want 0 0 10",
                     cnt, busy, err);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        do_reset();
        r0_rd = 1'b1;
        r0_addr = 24'h004444;
        tick();
        r0_rd = 1'b0;
        wait_fr_rd(n);
        serve(24'h004440, LD);
        checks++;
        if (r0_done !== 1'b1 || r0_line !== LD) begin
            errors++;
            $display("FAIL b2b_first: got %b %h want 1 %h", r0_done, r0_line, LD);
        end
        r0_rd = 1'b1;
        r0_addr = 24'h007777;
        tick();
        r0_rd = 1'b0;
        checks++;
        if (busy !== 1'b1 || r0_done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept: got busy %b done %b want 1 0",
                     busy, r0_done);
        end
        wait_fr_rd(n);
        checks++;
        if (n != 1 || fr_addr !== 24'h007770 || err !== 2'b00) begin
            errors++;
            $display("FAIL b2b_issue: got %0d %h %b want 1 007770 00",
                     n, fr_addr, err);
        end
        serve(24'h007770, LE);
        checks++;
        if (r0_done !== 1'b1 || r0_line !== LE || err !== 2'b00) begin
            errors++;
            $display("FAIL b2b_second: got %b %h %b want 1 %h 00",
                     r0_done, r0_line, err, LE);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset();
        r1_rd = 1'b1;
        r1_addr = 24'h001000;
        tick();
        r1_rd = 1'b0;
        wait_fr_rd(n);
        serve(24'h001000, LB);
        tick();
        r0_rd = 1'b1;
        r0_addr = 24'h002000;
        tick();
        r0_rd = 1'b0;
        wait_fr_rd(n);
        tick();
        r0_rd = 1'b1;
        tick();
        r0_rd = 1'b0;
        checks++;
        if (err !== 2'b01 || r1_line !== LB) begin
            errors++;
            $display("FAIL rstmid_pre: got %b %h want 01 %h", err, r1_line, LB);
        end
        #2;
        HRESETn = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || fr_rd !== 1'b0 || err !== 2'b00) begin
            errors++;
            $display("FAIL rstmid_async: got busy %b fr_rd %b err %b want 0 0 00",
                     busy, fr_rd, err);
        end
        checks++;
        if (r0_line !== '0 || r1_line !== '0 || fr_addr !== 24'h0) begin
            errors++;
            $display("FAIL rstmid_bufs: got %h %h %h want 0",
                     r0_line, r1_line, fr_addr);
        end
        #2;
        HRESETn = 1'b1;
        tick();
        fr_done = 1'b1;
        fr_line = LA;
        tick();
        fr_done = 1'b0;
        fr_line = '0;
        checks++;
        if (r0_done !== 1'b0 || r1_done !== 1'b0 || r0_line !== '0 ||
            busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_after: got %b%b %h busy %b want 00 0 0",
                     r0_done, r1_done, r0_line, busy);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_spurious();
        test_tie();
        test_dup();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
